// File: rtl/load_store_unit.sv
// load_store_unit: captures a load/store, runs one word-aligned req/ack bus access with timeout, returns the extended load data.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses without touching the bus.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        acc, is_b, is_h, misal;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, ld_n;
  logic [7:0]  rb;
  logic [15:0] rh;
  assign acc   = memRead | memWrite;
  assign is_b  = funct3[1:0] == 2'b00;
  assign is_h  = funct3[1:0] == 2'b01;
  assign stall = (state == IDLE && acc) || state == REQ;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = (is_h & addr[0]) | (~is_b & ~is_h & |addr[1:0]);
`else
  assign misal = 1'b0;
`endif
  always_comb begin
    be_n    = !memWrite ? 4'b1111 : is_b ? 4'b0001 << addr[1:0] : is_h ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_n = is_b ? {4{store_data[7:0]}} : is_h ? {2{store_data[15:0]}} : store_data;
    rb      = mem_rdata[{lo_q, 3'b000} +: 8];
    rh      = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_n    = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & rb[7]}}, rb}
            : f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & rh[15]}}, rh} : mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_q      <= '0;
      lo_q      <= '0;
      load_data <= '0;
      done      <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          f3_q <= funct3;
          lo_q <= addr[1:0];
          cnt  <= '0;
          if (misal) begin
            state   <= DONE;
            done    <= 1'b1;
            bus_err <= 1'b1;
            if (!memWrite) load_data <= '0;
          end else begin
            state     <= REQ;
            mem_req   <= 1'b1;
            mem_we    <= memWrite;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= be_n;
            mem_wdata <= memWrite ? wdata_n : '0;
          end
        end
        REQ: if (mem_ack) begin
          state   <= DONE;
          mem_req <= 1'b0;
          done    <= 1'b1;
          if (!mem_we) load_data <= ld_n;
        end else if (cnt == LAST) begin
          state   <= DONE;
          mem_req <= 1'b0;
          done    <= 1'b1;
          bus_err <= 1'b1;
          if (!mem_we) load_data <= '0;
        end else begin
          cnt <= cnt + 16'd1;
        end
        DONE: begin
          state   <= IDLE;
          done    <= 1'b0;
          bus_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory responder for the core's memory control signals (memRead, memWrite) and funct3 size/sign field.
- Captures an access in one cycle and drives a word-aligned request/acknowledge bus to data memory or a peripheral.
- Stalls the pipeline until the access completes, then returns the aligned, sign/zero-extended load result to writeback.
- Sits between the execute stage (ALU address, rs2 data) and the memory bus.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in REQ waiting for mem_ack before the access is aborted; range 1..65535.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- memRead  in  1  load requested by current instruction
- memWrite  in  1  store requested by current instruction
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address from ALU
- store_data  in  32  rs2 value
- load_data  out  32  extended load result, valid while done=1
- done  out  1  one-cycle pulse on access completion
- stall  out  1  hold the pipeline
- bus_err  out  1  one-cycle pulse, timeout or misaligned (see Optional Feature)
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  bus acknowledge; rdata valid in the same cycle
- mem_rdata  in  32  read word

Behaviour:
- Reset: state IDLE; all outputs 0, including load_data, mem_* and the timeout counter. Reset mid-access abandons the access immediately: mem_req drops the next cycle and no done is generated.
- States:
  - IDLE to REQ when memRead or memWrite is asserted. The access is captured in that cycle: addr, funct3, store_data and the write flag. If both are asserted, memWrite wins.
  - REQ: mem_req=1 with all mem_* fields stable. On mem_ack, go to DONE. On timeout expiry, go to DONE with an error.
  - DONE: lasts one cycle, then returns to IDLE unconditionally.
- stall:
  - Combinational 1 in IDLE when (memRead|memWrite).
  - 1 throughout REQ.
  - 0 in DONE, so the pipeline advances in the DONE cycle.
- A new access is never accepted in DONE. Minimum latency is request cycle, then REQ (ack in the same cycle), then DONE: 3 cycles, with a 2-cycle stall.
- Byte enables and store data:
  - B: mem_be = 4'b0001 << addr[1:0]; wdata = {4{sd[7:0]}}.
  - H: mem_be = 4'b0011 << {addr[1],1'b0}; wdata = {2{sd[15:0]}}.
  - W: mem_be = 4'b1111; wdata = sd.
  - Loads drive mem_be = 4'b1111.
- Load data:
  - mem_rdata is registered at ack.
  - The byte lane is selected by addr[1:0] and the halfword by addr[1].
  - B and H sign-extend from bit 7 and bit 15; BU and HU zero-extend.
  - load_data holds its value until the next load's DONE. Stores leave it unchanged.
- Illegal funct3 (011, 110, 111) is treated as W.
- Timeout:
  - The counter clears on entering REQ and increments every REQ cycle without ack.
  - When count == TIMEOUT_CYCLES-1 with no ack, go to DONE and pulse bus_err with done. A load in this case returns load_data=0.
  - An ack on the expiry cycle counts as success.
- mem_ack is ignored outside REQ.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - An H access with addr[0]=1, or a W access with addr[1:0]!=0, skips REQ: IDLE, then DONE.
  - done and bus_err are pulsed, no bus request is made, and a load returns 0.
  - stall is high only in the capture cycle.
- Undefined: low address bits for H and W are ignored; accesses proceed as aligned (H lane from addr[1], W full word). bus_err is only ever caused by timeout.

Test Plan:
- LW at 0x100, ack on the first REQ cycle with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111; done on cycle 3 with load_data=0xDEADBEEF; stall high for exactly 2 cycles.
- LB at 0x203, then LBU at 0x203, with rdata=0x80FF_00AA -> LB gives load_data=0xFFFFFF80; LBU gives 0x00000080.
- SH at 0x302, sd=0x1234ABCD, ack delayed 4 cycles -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, all held stable for 5 REQ cycles; done after ack; load_data unchanged.
- memRead and memWrite both high -> write performed; with TIMEOUT_CYCLES=4 and no ack -> exactly 4 REQ cycles, then done and bus_err together, load_data=0 on the timeout load.
- Reset asserted on the second REQ cycle -> next cycle mem_req=0 and all outputs 0, no done; a new LW afterwards completes normally.
- LW at 0x101: with LSU_MISALIGN_TRAP_EN -> no mem_req, done and bus_err on cycle 2; without the macro -> mem_addr=0x100, normal completion.
